// File: rtl/counter_share_arbiter_if.sv
// Bundle between the shared-counter arbiter, its requesters and the external counter.
interface counter_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [ID_W-1:0]        active_id;
  logic                   cnt_clr;
  logic                   cnt_en;
  logic [CNT_W-1:0]       count;

  // Arbiter side
  modport master (
    input  req, len, count,
    output gnt, done, busy, active_id, cnt_clr, cnt_en
  );

  // Requesters plus counter side
  modport slave (
    output req, len, count,
    input  gnt, done, busy, active_id, cnt_clr, cnt_en
  );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter that time-shares one external up-counter between N_REQ requesters:
// grant, clear the counter, count up to the latched length, then pulse done.
module counter_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ID_W  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  counter_share_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic               clr_q, clr_d;

  logic [ID_W-1:0]    pick;
  logic               pick_vld;
  logic [CNT_W-1:0]   len_pick;
  logic [ID_W-1:0]    rr_next;
  logic               owner_req;

  // First requester at or above rr_q, wrapping modulo N_REQ
  always_comb begin
    int unsigned c;
    pick     = '0;
    pick_vld = 1'b0;
    c        = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      c = (32'(rr_q) + k) % N_REQ;
      if (!pick_vld && bus.req[ID_W'(c)]) begin
        pick     = ID_W'(c);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    len_pick = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == ID_W'(i)) len_pick = bus.len[i*CNT_W +: CNT_W];
    end
  end

  assign rr_next   = ID_W'((32'(id_q) + 32'd1) % N_REQ);
  assign owner_req = bus.req[id_q];

  // Counting stops combinationally the cycle Count reaches the target or the owner lets go
  assign bus.cnt_en = (state_q == S_RUN) && owner_req && (bus.count != tgt_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          id_d    = pick;
          tgt_d   = len_pick;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR, S_RUN: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          rr_d    = rr_next;
          id_d    = '0;
        end else if (state_q == S_CLEAR) begin
          state_d = (tgt_q == '0) ? S_DONE : S_RUN;
        end else if (bus.count == tgt_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = rr_next;
        id_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered
    busy_d = (state_d != S_IDLE);
    gnt_d  = busy_d ? (N_REQ'(1) << id_d) : '0;
    done_d = (state_d == S_DONE) ? (N_REQ'(1) << id_d) : '0;
    clr_d  = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      rr_q    <= '0;
      tgt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = id_q;
  assign bus.cnt_clr   = clr_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: timeline-based reference model checked every cycle,
// external counter model, and directed scenarios with hand-computed latencies and orders.
module tb_counter_share_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  counter_share_arbiter_if #(.N_REQ(N), .CNT_W(W), .ID_W(2)) bus ();

  counter_share_arbiter #(.N_REQ(N), .CNT_W(W), .ID_W(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared external counter
  initial bus.count = '0;
  always @(posedge clk) begin
    if (bus.cnt_clr)     bus.count <= '0;
    else if (bus.cnt_en) bus.count <= bus.count + 8'd1;
  end

  // Reference: owner and age (cycles since grant; 1 = clear cycle)
  int m_owner = -1;
  int m_age   = 0;
  int m_tgt   = 0;
  int m_rr    = 0;

  function automatic int done_age(input int tgt);
    return (tgt == 0) ? 2 : tgt + 3;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_owner = -1;
      m_rr    = 0;
      m_age   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (m_owner < 0 && bus.req[c]) begin
          m_owner = c;
          m_tgt   = int'(bus.len[c*W +: W]);
          m_age   = 1;
        end
      end
    end else if (m_age == done_age(m_tgt) || !bus.req[m_owner]) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_age++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    if (cyc >= 1) begin
      int en_exp;
      int has;
      has    = (m_owner >= 0) ? 1 : 0;
      en_exp = (has == 1 && m_tgt > 0 && m_age >= 2 && m_age < m_tgt + 2 && bus.req[m_owner]) ? 1 : 0;
      chk("busy", 32'(bus.busy), 32'(has));
      chk("gnt", 32'(bus.gnt), (has == 1) ? (32'd1 << m_owner) : 32'd0);
      chk("done", 32'(bus.done), (has == 1 && m_age == done_age(m_tgt)) ? (32'd1 << m_owner) : 32'd0);
      chk("cnt_clr", 32'(bus.cnt_clr), (has == 1 && m_age == 1) ? 32'd1 : 32'd0);
      chk("active_id", 32'(bus.active_id), (has == 1) ? 32'(m_owner) : 32'd0);
      chk("cnt_en", 32'(bus.cnt_en), 32'(en_exp));
      if (bus.cnt_clr && bus.cnt_en) chk("clr_en_exclusive", 32'd1, 32'd0);
      if (has == 1 && m_tgt > 0 && m_age >= 2 && m_age <= m_tgt + 2)
        chk("count", 32'(bus.count), 32'(m_age - 2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int dcyc, output int did);
    dcyc = -1;
    did  = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        dcyc = cyc;
        for (int b = 0; b < N; b++) if (bus.done[b]) did = b;
        break;
      end
    end
    if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_count(input logic [7:0] val, input int max, output int acyc);
    acyc = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus.count == val) begin
        acyc = cyc;
        break;
      end
    end
    if (acyc < 0) chk("count_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t, d, id, a;
    int dl[$];
    int il[$];
    bus.req = '0;
    bus.len = '0;
    repeat (3) step();
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    step();

    // Single request, length 3
    bus.len[0*W +: W] = 8'd3;
    bus.req = 4'b0001;
    t = cyc;
    wait_done(20, d, id);
    chk("t1_done_latency", 32'(d - t), 32'd6);
    chk("t1_done_id", 32'(id), 32'd0);
    chk("t1_count_hold", 32'(bus.count), 32'd3);
    step();
    bus.req = '0;
    @(negedge clk);
    chk("t1_busy_after", 32'(bus.busy), 32'd0);

    // Zero length
    step();
    bus.len[2*W +: W] = 8'd0;
    bus.req = 4'b0100;
    t = cyc;
    wait_done(10, d, id);
    chk("t2_done_latency", 32'(d - t), 32'd2);
    chk("t2_done_id", 32'(id), 32'd2);
    step();
    bus.req = '0;

    // Round-robin from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) bus.len[i*W +: W] = 8'd2;
    bus.req = 4'b1111;
    t = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_done(20, d, id);
      dl.push_back(d);
      il.push_back(id);
    end
    step();
    bus.req = '0;
    chk("t3_first_latency", 32'(dl[0] - t), 32'd5);
    chk("t3_order0", 32'(il[0]), 32'd0);
    chk("t3_order1", 32'(il[1]), 32'd1);
    chk("t3_order2", 32'(il[2]), 32'd2);
    chk("t3_order3", 32'(il[3]), 32'd3);
    chk("t3_order4", 32'(il[4]), 32'd0);
    for (int i = 1; i < 5; i++) chk("t3_gap", 32'(dl[i] - dl[i-1]), 32'd6);

    // Maximum length
    step();
    bus.len[1*W +: W] = 8'd255;
    bus.req = 4'b0010;
    t = cyc;
    wait_done(300, d, id);
    chk("t4_done_latency", 32'(d - t), 32'd258);
    chk("t4_done_id", 32'(id), 32'd1);
    chk("t4_count_no_wrap", 32'(bus.count), 32'd255);
    step();
    bus.req = '0;

    // Abandon with a pending requester
    step();
    bus.len[0*W +: W] = 8'd10;
    bus.len[1*W +: W] = 8'd2;
    bus.req = 4'b0011;
    wait_count(8'd4, 40, a);
    bus.req = 4'b0010;
    @(negedge clk);
    chk("t5_en_drop", 32'(bus.cnt_en), 32'd0);
    chk("t5_no_done", 32'(bus.done), 32'd0);
    step();
    @(negedge clk);
    chk("t5_idle_next", 32'(bus.busy), 32'd0);
    wait_done(20, d, id);
    chk("t5_next_id", 32'(id), 32'd1);
    chk("t5_next_latency", 32'(d - (a + 1)), 32'd5);
    step();
    bus.req = '0;

    // Reset mid-run, pointer returns to 0
    step();
    bus.len[0*W +: W] = 8'd9;
    bus.len[3*W +: W] = 8'd9;
    bus.req = 4'b1001;
    wait_count(8'd5, 40, a);
    chk("t6_owner_before", 32'(bus.active_id), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_gnt_reset", 32'(bus.gnt), 32'd0);
    chk("t6_busy_reset", 32'(bus.busy), 32'd0);
    chk("t6_en_reset", 32'(bus.cnt_en), 32'd0);
    wait_done(30, d, id);
    chk("t6_first_after_reset", 32'(id), 32'd0);
    step();
    bus.req = '0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_share_arbiter.md
Name: counter_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one external 8-bit up-counter (clock, enable, count output) between N_REQ requesters.
- Each requester asks for an interval of Len counts. The block grants one requester, clears the counter, enables it until Count equals Len, then pulses Done to that requester.
- Sits between timing clients and the shared counter. It is the only driver of the counter's enable and clear.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 8, counter / length width
ID_W, 2, width of Active_Id; must equal ceil(log2(N_REQ))

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous active-high reset
Req  in  N_REQ  per-requester level request; held until Done or abandoned
Len  in  N_REQ*CNT_W  packed target lengths; slice i = Len[i*CNT_W +: CNT_W]; sampled only at grant
Gnt  out  N_REQ  one-hot grant; high in CLEAR, RUN, DONE
Done  out  N_REQ  one-cycle completion pulse to the granted requester
Busy  out  1  high in any state other than IDLE
Active_Id  out  ID_W  index of the granted requester; 0 when idle
Cnt_Clr  out  1  synchronous clear to the shared counter (counter reads 0 on the next cycle)
Cnt_En  out  1  count enable to the shared counter
Count  in  CNT_W  shared counter value

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Rst). All state is registered on the rising edge of Clk.
- Reset:
  - state=IDLE, rr_ptr=0, tgt=0, Active_Id=0.
  - Gnt=0, Done=0, Busy=0, Cnt_Clr=0, Cnt_En=0.
  - Rst asserted mid-operation aborts the transaction: no Done is issued and all outputs return to reset values on the next edge.
- IDLE:
  - If Req is nonzero, select the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Register idx into Active_Id, latch Len slice into tgt, go to CLEAR.
  - If Req=0, stay in IDLE.
- CLEAR (exactly 1 cycle):
  - Gnt[idx]=1, Cnt_Clr=1, Cnt_En=0.
  - If tgt==0, go to DONE; else go to RUN.
- RUN:
  - Cnt_En = (Count != tgt), combinational, so the counter stops exactly at tgt.
  - When Count==tgt, Cnt_En=0 and the next state is DONE.
- DONE (exactly 1 cycle):
  - Done[idx]=1 and Gnt[idx]=1.
  - rr_ptr <= (idx+1) mod N_REQ; next state is IDLE.
- Abandon:
  - If Req[idx] drops while in CLEAR or RUN, Cnt_En=0 in that cycle and the block returns to IDLE next cycle.
  - No Done is issued; rr_ptr still advances to idx+1.
- Latency:
  - Request seen in IDLE at cycle t: CLEAR at t+1, RUN from t+2 with Count=0, DONE at t+tgt+3.
  - tgt==0: DONE at t+2.
  - At least one IDLE cycle separates transactions.
- Fairness:
  - A requester holding Req after its Done is re-arbitrated behind the others.
  - The maximum wait is N_REQ-1 transactions.
- Width rules:
  - Count is compared to tgt at full CNT_W.
  - tgt=2^CNT_W-1 is legal; the counter never wraps under this block's control.
- Len changes after grant are ignored.
- Req bits of non-granted requesters have no effect outside IDLE.
- Invariants: Gnt and Done are one-hot or zero; Done implies Gnt on the same bit; Cnt_Clr and Cnt_En are never high together.

Test Plan:
- Single request: Req=0001, Len0=3 -> Gnt=0001 from t+1, Cnt_Clr high at t+1, Count goes 0,1,2,3 then holds, Done[0] at t+6, Busy low at t+7.
- Zero length: Req=0100, Len2=0 -> CLEAR at t+1, Done[2] at t+2, Cnt_En never asserted.
- Round-robin: Req=1111 held with all Len=2 -> grant order 0,1,2,3,0; each Done followed by exactly one IDLE cycle.
- Max length: Len1=255 -> Count reaches 255 and stops with no wrap to 0; Done[1] at t+258.
- Abandon: Req0 with Len0=10 drops when Count=4 -> Cnt_En=0 that cycle, IDLE next cycle, no Done; a pending Req1 is granted next.
- Reset mid-run: Rst=1 while Count=5 -> next edge Gnt=0, Busy=0, Cnt_En=0, no Done; after release, Req0 is granted first (rr_ptr=0).
